// File: rtl/gates7_pkg.sv
// gates7_pkg
// Shared definitions for the gates7 stimulus sequencer:
//   - state_e        : sequencer FSM state encoding
//   - IDX_*          : bit positions of each gate function within f_in
//   - gates7_expect  : expected seven-function output for a given (a, b)
package gates7_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ADV  = 2'd2,
        FIN  = 2'd3
    } state_e;

    localparam int IDX_AND  = 6;
    localparam int IDX_OR   = 5;
    localparam int IDX_NOT  = 4;
    localparam int IDX_NAND = 3;
    localparam int IDX_NOR  = 2;
    localparam int IDX_XOR  = 1;
    localparam int IDX_XNOR = 0;

    function automatic logic [6:0] gates7_expect(input logic a, input logic b);
        logic [6:0] f;
        f           = '0;
        f[IDX_AND]  = a & b;
        f[IDX_OR]   = a | b;
        f[IDX_NOT]  = ~a;
        f[IDX_NAND] = ~(a & b);
        f[IDX_NOR]  = ~(a | b);
        f[IDX_XOR]  = a ^ b;
        f[IDX_XNOR] = ~(a ^ b);
        return f;
    endfunction

endpackage

// File: rtl/gates7_ref.sv
// gates7_ref
// Combinational golden model of the seven-function gate block.
// Ports:
//   a_i, b_i : gate inputs
//   f_o[6:0] : {and, or, not(a), nand, nor, xor, xnor}
module gates7_ref
    import gates7_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [6:0] f_o
);

    assign f_o = gates7_expect(a_i, b_i);

endmodule

// File: rtl/gates7_stim_seq.sv
// gates7_stim_seq
// Clocked, restartable stimulus source for the seven-function gate block.
// Steps {b,a} through 00,01,10,11 for LOOPS passes, holding each vector
// STEP_CYCLES cycles followed by one advance cycle, and strobes `sample`
// in the last hold cycle of each vector.
//
// Optional feature (macro GATES7_CHECK_EN): at each sample, f_in is
// compared with the golden model and mismatching samples are counted in a
// saturating err_cnt. Without the macro err_cnt/err_flag are tied to 0
// and f_in is ignored; sequencing is identical.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : one-cycle start pulse, honoured only when idle
//   f_in[6:0]       : gate block outputs {and,or,not,nand,nor,xor,xnor}
//   a, b            : stimulus to the gate block
//   vec_valid       : a/b hold a vector inside a run
//   sample          : last hold cycle strobe
//   busy, done      : run in progress, one-cycle completion pulse
//   err_cnt, err_flag : mismatch count for the current/last run, nonzero flag
module gates7_stim_seq
    import gates7_pkg::*;
#(
    parameter int STEP_CYCLES = 4,
    parameter int LOOPS       = 2,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       f_in,
    output logic             a,
    output logic             b,
    output logic             vec_valid,
    output logic             sample,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_flag
);

    localparam logic [7:0] HOLD_LAST = 8'(STEP_CYCLES - 1);
    localparam logic [7:0] LOOP_LAST = 8'(LOOPS - 1);

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] loop_q, loop_d;
    logic [1:0] idx_q, idx_d;
    logic       done_q, done_d;
    logic       clr_err;
    logic       sample_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            loop_q  <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            loop_q  <= loop_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        loop_d    = loop_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        clr_err   = 1'b0;
        sample_en = 1'b0;
        case (state_q)
            IDLE: begin
                // A start landing on the done cycle is not taken; it must
                // still be present one cycle later to begin a new run.
                if (start && !done_q) begin
                    clr_err = 1'b1;
                    idx_d   = 2'd0;
                    hold_d  = '0;
                    loop_d  = '0;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    sample_en = 1'b1;
                    hold_d    = '0;
                    state_d   = ADV;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            ADV: begin
                if (idx_q == 2'd3 && loop_q == LOOP_LAST) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        loop_d = loop_q + 8'd1;
                    end
                    state_d = HOLD;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                idx_d   = 2'd0;
                loop_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign a         = idx_q[0];
    assign b         = idx_q[1];
    assign vec_valid = (state_q == HOLD);
    assign sample    = sample_en;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

`ifdef GATES7_CHECK_EN
    logic [6:0]       exp_f;
    logic [ERR_W-1:0] err_q;

    gates7_ref u_ref (
        .a_i (idx_q[0]),
        .b_i (idx_q[1]),
        .f_o (exp_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (clr_err) begin
            err_q <= '0;
        end else if (sample_en && (f_in != exp_f) && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
        end
    end

    assign err_cnt  = err_q;
    assign err_flag = |err_q;
`else
    logic unused_chk;
    assign unused_chk = ^{f_in, clr_err};
    assign err_cnt    = '0;
    assign err_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_gates7_stim_seq.sv
module tb_gates7_stim_seq;

`ifdef GATES7_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_fail = 0;

    // Three instances share clk/rst/start:
    //   0: STEP=4 LOOPS=1 ERR_W=8, correct gate block
    //   1: STEP=4 LOOPS=2 ERR_W=8, xor output stuck at 0
    //   2: STEP=2 LOOPS=2 ERR_W=2, all outputs inverted
    logic       a_w[3], b_w[3], vv_w[3], smp_w[3], busy_w[3], done_w[3], flag_w[3];
    logic [6:0] f_w[3];
    logic [7:0] err0, err1;
    logic [1:0] err2;

    function automatic logic [6:0] gate_out(input logic a, input logic b);
        return {a & b, a | b, ~a, ~(a & b), ~(a | b), a ^ b, ~(a ^ b)};
    endfunction

    assign f_w[0] = gate_out(a_w[0], b_w[0]);
    assign f_w[1] = gate_out(a_w[1], b_w[1]) & 7'b1111101;
    assign f_w[2] = ~gate_out(a_w[2], b_w[2]);

    gates7_stim_seq #(.STEP_CYCLES(4), .LOOPS(1), .ERR_W(8)) u_d0 (
        .clk(clk), .rst(rst), .start(start), .f_in(f_w[0]),
        .a(a_w[0]), .b(b_w[0]), .vec_valid(vv_w[0]), .sample(smp_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .err_cnt(err0), .err_flag(flag_w[0]));

    gates7_stim_seq #(.STEP_CYCLES(4), .LOOPS(2), .ERR_W(8)) u_d1 (
        .clk(clk), .rst(rst), .start(start), .f_in(f_w[1]),
        .a(a_w[1]), .b(b_w[1]), .vec_valid(vv_w[1]), .sample(smp_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .err_cnt(err1), .err_flag(flag_w[1]));

    gates7_stim_seq #(.STEP_CYCLES(2), .LOOPS(2), .ERR_W(2)) u_d2 (
        .clk(clk), .rst(rst), .start(start), .f_in(f_w[2]),
        .a(a_w[2]), .b(b_w[2]), .vec_valid(vv_w[2]), .sample(smp_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .err_cnt(err2), .err_flag(flag_w[2]));

    typedef struct { int cyc; int ba; } samp_t;
    typedef struct { int cyc; int err; int flag; } done_t;

    samp_t sq[$];
    done_t dq[3][$];
    samp_t ms;
    done_t md;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int err_of(input int i);
        case (i)
            0:       return int'(err0);
            1:       return int'(err1);
            default: return int'(err2);
        endcase
    endfunction

    // Hand-computed expectations for a run whose start is taken at cycle sc.
    task automatic push_run(input int sc);
        for (int k = 0; k < 4; k++) sq.push_back('{sc + 5 * k + 3, k});
        dq[0].push_back('{sc + 21, 0, 0});
        dq[1].push_back('{sc + 41, CHK ? 4 : 0, CHK ? 1 : 0});
        dq[2].push_back('{sc + 25, CHK ? 3 : 0, CHK ? 1 : 0});
    endtask

    task automatic run_start(output int sc);
        @(negedge clk);
        sc = cyc + 1;
        push_run(sc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int left;
        left = 1;
        for (int i = 0; i < 300 && left != 0; i++) begin
            @(posedge clk);
            #1;
            left = sq.size() + dq[0].size() + dq[1].size() + dq[2].size();
        end
        chk(nm, left, 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic chk_idle(input string nm);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_d%0d_ab", nm, i), int'({b_w[i], a_w[i]}), 0);
            chk($sformatf("%s_d%0d_busy", nm, i), int'(busy_w[i]), 0);
        end
    endtask

    // Monitor: pops expectations whenever a DUT presents sample or done.
    always @(negedge clk) begin
        if (!rst) begin
            if (smp_w[0]) begin
                chk("d0_sample_expected", int'(sq.size() != 0), 1);
                if (sq.size() != 0) begin
                    ms = sq.pop_front();
                    chk("d0_sample_cycle", cyc, ms.cyc);
                    chk("d0_sample_ab", int'({b_w[0], a_w[0]}), ms.ba);
                    chk("d0_sample_vec_valid", int'(vv_w[0]), 1);
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (done_w[i]) begin
                    chk($sformatf("d%0d_done_expected", i), int'(dq[i].size() != 0), 1);
                    if (dq[i].size() != 0) begin
                        md = dq[i].pop_front();
                        chk($sformatf("d%0d_done_cycle", i), cyc, md.cyc);
                        chk($sformatf("d%0d_err_cnt", i), err_of(i), md.err);
                        chk($sformatf("d%0d_err_flag", i), int'(flag_w[i]), md.flag);
                        chk($sformatf("d%0d_done_busy", i), int'(busy_w[i]), 0);
                        chk($sformatf("d%0d_done_ab", i), int'({b_w[i], a_w[i]}), 0);
                    end
                end
            end
        end
    end

    int sc;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset with no start.
        repeat (6) begin
            @(negedge clk);
            chk("idle_ab", int'({b_w[0], a_w[0]}), 0);
            chk("idle_busy", int'(busy_w[0]), 0);
            chk("idle_vv", int'(vv_w[0]), 0);
            chk("idle_err", int'(err0), 0);
            chk("idle_done", int'(done_w[0]), 0);
        end

        // Basic run.
        run_start(sc);
        drain("run1_drain");
        chk_idle("after_run1");

        // Second start while busy must be ignored.
        run_start(sc);
        repeat (6) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("run2_drain");
        chk_idle("after_run2");

        // Asynchronous reset during HOLD of vector 10.
        run_start(sc);
        while (cyc < sc + 11) @(negedge clk);
        chk("pre_rst_ab", int'({b_w[0], a_w[0]}), 2);
        #2;
        rst = 1'b1;
        sq.delete();
        for (int i = 0; i < 3; i++) dq[i].delete();
        #1;
        chk_idle("async_rst");
        chk("async_rst_vv", int'(vv_w[0]), 0);
        chk("async_rst_sample", int'(smp_w[0]), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (45) @(negedge clk);
        chk_idle("post_abort");

        // Fresh run after the aborted one.
        run_start(sc);
        drain("run3_drain");
        chk_idle("after_run3");

        chk("sample_queue_empty", sq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
